memory_32x4: RTL and testbench



---
 rtl/memory_32x4_pkg.sv | 18 +
 rtl/memory_32x4.sv | 65 ++++++
 tb/tb_memory_32x4.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/memory_32x4_pkg.sv
// Shared types and default sizes for the memory_32x4 storage leaf and the wide
// wrappers that tile it. Wrappers drive every 32-bit slice with the same
// mem_int_t control bundle.
package memory_32x4_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    // Shared read/write control bundle: one read port and one write port.
    typedef struct packed {
        logic [ADDR_W-1:0] rd_address;
        logic              rd_vld;
        logic [ADDR_W-1:0] wr_address;
        logic              wr_vld;
    } mem_int_t;

endpackage

// File: rtl/memory_32x4.sv
// memory_32x4: 4 x 32-bit storage with one write port and one registered read
// port, all on clk. The array memory_32_4_memory keeps this exact name so that
// upper levels can reach it hierarchically (for example, to preload it). The
// array has no reset, so preloaded contents survive reset.
//
// Optional macro MEM_RDW_BYPASS_EN: when defined, a read and a write to the same
// address in the same cycle return the new write data (write-first). When
// undefined, they return the old stored word (read-first). In both cases the
// array holds the new word afterwards.
module memory_32x4
    import memory_32x4_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  mem_int_t          m,
    input  logic [DATA_W-1:0] m_wr_data,
    output logic [DATA_W-1:0] m_rd_data
);

    // Storage array. It has no reset so that block RAM can be inferred and
    // preloaded contents survive reset.
    logic [DATA_W-1:0] memory_32_4_memory [0:DEPTH-1];

    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] rd_data_next;
    logic              rdw_hit;

    // A read and a write that target the same word in the same cycle.
    assign rdw_hit = m.rd_vld && m.wr_vld && (m.rd_address == m.wr_address);

    // Select the word the read register captures at the next edge.
    always_comb begin
        rd_data_next = memory_32_4_memory[m.rd_address];
`ifdef MEM_RDW_BYPASS_EN
        if (rdw_hit) begin
            rd_data_next = m_wr_data;
        end
`else
        // Read-first: the old word is already selected, so a collision needs
        // no special handling.
        if (rdw_hit) begin
            rd_data_next = memory_32_4_memory[m.rd_address];
        end
`endif
    end

    // Write port. Reset suppresses the write but leaves the stored words alone.
    always_ff @(posedge clk) begin
        if (!reset && m.wr_vld) begin
            memory_32_4_memory[m.wr_address] <= m_wr_data;
        end
    end

    // Registered read port. Reset clears it, and it holds its value while rd_vld is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (m.rd_vld) begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign m_rd_data = rd_data_reg;

endmodule

// File: tb/tb_memory_32x4.sv
// Testbench for memory_32x4. The stimulus process drives one transaction per
// cycle. For each transaction it pushes the expected m_rd_data, taken from a
// plain array model of the memory, onto a scoreboard queue. A separate monitor
// pops one entry after every rising edge and compares it with the DUT output.
module tb_memory_32x4;
    import memory_32x4_pkg::*;

    logic              clk;
    logic              reset;
    mem_int_t          m;
    logic [DATA_W-1:0] m_wr_data;
    logic [DATA_W-1:0] m_rd_data;

    memory_32x4 dut (
        .clk       (clk),
        .reset     (reset),
        .m         (m),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] exp;
        string             tag;
    } sb_t;

    sb_t               sb_q[$];
    int                chk_cnt  = 0;
    int                pass_cnt = 0;

    // Reference model: the stored words and the value the read port shows.
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] model_rd;

    // Drive one cycle of stimulus, then record what the read port must show
    // after the coming edge.
    task automatic cycle(input logic rst, input logic rv, input logic [ADDR_W-1:0] ra,
                         input logic wv, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input string tag);
        sb_t e;
        @(negedge clk);
        reset        = rst;
        m.rd_vld     = rv;
        m.rd_address = ra;
        m.wr_vld     = wv;
        m.wr_address = wa;
        m_wr_data    = wd;
        if (rst) begin
            model_rd = '0;
        end else begin
            if (rv) begin
`ifdef MEM_RDW_BYPASS_EN
                model_rd = (wv && wa == ra) ? wd : model_mem[ra];
`else
                model_rd = model_mem[ra];
`endif
            end
            if (wv) model_mem[wa] = wd;
        end
        e.exp = model_rd;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the output with the oldest expected value.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_cnt++;
            if (m_rd_data !== e.exp) begin
                $display("FAIL %s: m_rd_data got %h, expected %h", e.tag, m_rd_data, e.exp);
            end else begin
                pass_cnt++;
                $display("ok   %s: m_rd_data %h", e.tag, m_rd_data);
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] pre [DEPTH];
        logic [DATA_W-1:0] vals [DEPTH];
        int                wait_cyc;
        pre[0] = 32'h11111111; pre[1] = 32'h22222222;
        pre[2] = 32'h33333333; pre[3] = 32'h44444444;
        vals[0] = 32'hA0A0A0A0; vals[1] = 32'hB1B1B1B1;
        vals[2] = 32'hC2C2C2C2; vals[3] = 32'hD3D3D3D3;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
        model_rd = '0;

        reset = 1'b1;
        m = '0;
        m_wr_data = '0;

        // Reset state.
        cycle(1, 0, 0, 0, 0, 0, "reset0");
        cycle(1, 1, 2, 1, 2, 32'h0BADF00D, "reset_rd_wr");
        cycle(0, 0, 0, 0, 0, 0, "post_reset_idle");

        // Preload the array through the write port. The read port must hold 0.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 0, 1, ADDR_W'(i), pre[i], $sformatf("preload%0d", i));
        end
        // Reset must keep the array contents.
        cycle(1, 0, 0, 0, 0, 0, "reset_keeps_array");

        cycle(0, 1, 2, 0, 0, 0, "read_addr2");

        cycle(0, 0, 0, 1, 1, 32'hDEADBEEF, "write_addr1");
        cycle(0, 1, 1, 0, 0, 0, "read_addr1");
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, $sformatf("hold%0d", i));

        // Same-cycle read and write to address 3.
        cycle(0, 1, 3, 1, 3, 32'hCAFEF00D, "rdw_addr3");
        cycle(0, 1, 3, 0, 0, 0, "reread_addr3");

        // Reset mid-stream. The write issued during reset must be lost.
        cycle(1, 1, 0, 1, 0, 32'h12345678, "reset_midstream");
        cycle(0, 1, 0, 0, 0, 0, "read_addr0_after_reset");

        // Back-to-back: write addresses 0..3 while reading addresses 3..0.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, ADDR_W'(DEPTH - 1 - i), 1, ADDR_W'(i), vals[i], $sformatf("b2b%0d", i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, ADDR_W'(i), 0, 0, 0, $sformatf("b2b_readback%0d", i));
        end

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            logic              r_rst;
            logic              r_rv;
            logic              r_wv;
            logic [ADDR_W-1:0] r_ra;
            logic [ADDR_W-1:0] r_wa;
            logic [DATA_W-1:0] r_wd;
            r_rst = ($urandom_range(0, 19) == 0);
            r_rv  = 1'($urandom_range(0, 1));
            r_wv  = 1'($urandom_range(0, 1));
            r_ra  = ADDR_W'($urandom_range(0, DEPTH - 1));
            r_wa  = ADDR_W'($urandom_range(0, DEPTH - 1));
            r_wd  = $urandom;
            cycle(r_rst, r_rv, r_ra, r_wv, r_wa, r_wd, $sformatf("rand%0d", n));
        end

        @(negedge clk);
        m.rd_vld = 1'b0;
        m.wr_vld = 1'b0;
        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
